// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : uart_pkg                                                |
// | Purpose  : Shared constants for the UART peripheral: register word |
// |            offsets, STATUS/CTRL bit positions, FSM encodings.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package uart_pkg;

   // Register word offsets (addr[3:2])
   localparam logic [1:0] UART_DATA = 2'd0;
   localparam logic [1:0] UART_STAT = 2'd1;
   localparam logic [1:0] UART_CTRL = 2'd2;
   localparam logic [1:0] UART_DIV  = 2'd3;

   // STATUS bit indices
   localparam int C_ST_TX_BUSY   = 0;
   localparam int C_ST_TX_EMPTY  = 1;
   localparam int C_ST_TX_FULL   = 2;
   localparam int C_ST_RX_NEMPTY = 3;
   localparam int C_ST_RX_FULL   = 4;
   localparam int C_ST_RX_OVF    = 5;

   // CTRL bit indices
   localparam int C_CTRL_EN    = 0;
   localparam int C_CTRL_RX_IE = 1;
   localparam int C_CTRL_TX_IE = 2;

   // Serial FSM encodings, shared by TX and RX
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_periph_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface: uart_fifo_periph_if                                     |
// | Purpose  : CPU-side register bus of the UART peripheral.           |
// |   addr[1:0] word offset, we/re 1-cycle strobes, din write data,    |
// |   dout combinational read data, irq level interrupt.               |
// |   master = bridge side, slave = peripheral side.                   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface uart_fifo_periph_if;
   logic [1:0]  addr;
   logic        we;
   logic        re;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   modport master (output addr, output we, output re, output din,
                   input  dout, input  irq);
   modport slave  (input  addr, input  we, input  re, input  din,
                   output dout, output irq);
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_sync_fifo                                          |
// | Purpose  : Single-clock FIFO with show-ahead head output.          |
// |   i_push/i_wdata  write side; dropped when full unless popping     |
// |   i_pop           advance head; ignored when empty unless pushing  |
// |   o_rdata         current head (0 when empty)                      |
// |   o_full/o_empty/o_count  occupancy                                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  wire logic                     clk,
   input  wire logic                     sys_rstn,
   input  wire logic                     i_push,
   input  wire logic                     i_pop,
   input  wire logic [WIDTH-1:0]         i_wdata,
   output logic      [WIDTH-1:0]         o_rdata,
   output logic                          o_full,
   output logic                          o_empty,
   output logic      [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   // A simultaneous pop frees the slot a full push needs, and a
   // simultaneous push supplies the entry an empty pop consumes.
   assign w_do_push = i_push & (~o_full  | i_pop);
   assign w_do_pop  = i_pop  & (~o_empty | i_push);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/uart_fifo_periph.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_fifo_periph                                        |
// | Purpose  : Memory-mapped 8N1 UART with TX/RX FIFOs, programmable   |
// |            baud divisor and maskable level IRQ.                    |
// |   clk, sys_rstn   clock, synchronous active-low reset              |
// |   bus (slave)     addr/we/re/din in, dout/irq out                  |
// |   uart_rxd        asynchronous serial input                        |
// |   uart_txd        serial output, idle high                         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module uart_fifo_periph
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RESET  = 217,
   parameter int DIV_WIDTH  = 16
) (
   input  wire logic          clk,
   input  wire logic          sys_rstn,
   uart_fifo_periph_if.slave  bus,
   input  wire logic          uart_rxd,
   output logic               uart_txd
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Control / status registers
   logic                 r_en, r_rx_ie, r_tx_ie, r_rx_ovf, r_irq;
   logic [DIV_WIDTH-1:0] r_div;

   // Bus decode
   logic w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_div, w_rx_pop;
   assign w_wr_data = bus.we & (bus.addr == UART_DATA);
   assign w_wr_stat = bus.we & (bus.addr == UART_STAT);
   assign w_wr_ctrl = bus.we & (bus.addr == UART_CTRL);
   assign w_wr_div  = bus.we & (bus.addr == UART_DIV);
   assign w_rx_pop  = bus.re & (bus.addr == UART_DATA);

   // FIFOs
   logic [7:0]    w_tx_rdata, w_rx_rdata;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [CW-1:0] w_tx_count, w_rx_count;
   logic          w_tx_load, w_rx_push;
   logic [7:0]    r_rx_shift;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .sys_rstn(sys_rstn),
      .i_push(w_wr_data), .i_pop(w_tx_load), .i_wdata(bus.din[7:0]),
      .o_rdata(w_tx_rdata), .o_full(w_tx_full), .o_empty(w_tx_empty),
      .o_count(w_tx_count));

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .sys_rstn(sys_rstn),
      .i_push(w_rx_push), .i_pop(w_rx_pop), .i_wdata(r_rx_shift),
      .o_rdata(w_rx_rdata), .o_full(w_rx_full), .o_empty(w_rx_empty),
      .o_count(w_rx_count));

   // Bit-period reload values; a new DIV is picked up at the next reload
   logic [DIV_WIDTH-1:0] w_div_m1, w_div_half_m1, w_div_wr;
   assign w_div_m1      = r_div - DIV_WIDTH'(1);
   assign w_div_half_m1 = (r_div >> 1) - DIV_WIDTH'(1);
   assign w_div_wr      = bus.din[DIV_WIDTH-1:0];

   // ---------------- TX engine ----------------
   logic [1:0]           r_tx_state;
   logic [DIV_WIDTH-1:0] r_tx_cnt;
   logic [2:0]           r_tx_bit;
   logic [7:0]           r_tx_shift;
   logic                 w_tx_busy, w_tx_tick;

   assign w_tx_busy = (r_tx_state != S_IDLE);
   assign w_tx_tick = (r_tx_cnt == '0);
   // Load a new byte from IDLE, or from the end of STOP for gapless frames
   assign w_tx_load = r_en & ~w_tx_empty &
                      ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_tick));
   assign uart_txd  = (r_tx_state == S_START) ? 1'b0 :
                      (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;

   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
      end else if (w_tx_load) begin
         r_tx_state <= S_START;
         r_tx_cnt   <= w_div_m1;
         r_tx_shift <= w_tx_rdata;
      end else if (w_tx_busy) begin
         if (!w_tx_tick) begin
            r_tx_cnt <= r_tx_cnt - DIV_WIDTH'(1);
         end else begin
            r_tx_cnt <= w_div_m1;
            case (r_tx_state)
               S_START: begin
                  r_tx_state <= S_DATA;
                  r_tx_bit   <= '0;
               end
               S_DATA: begin
                  if (r_tx_bit == 3'd7) begin
                     r_tx_state <= S_STOP;
                  end else begin
                     r_tx_bit   <= r_tx_bit + 3'd1;
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  end
               end
               default: r_tx_state <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- RX engine ----------------
   logic                 r_rx_s1, r_rx_s2, r_rx_prev;
   logic [1:0]           r_rx_state;
   logic [DIV_WIDTH-1:0] r_rx_cnt;
   logic [2:0]           r_rx_bit;
   logic                 w_rx_tick;

   assign w_rx_tick = (r_rx_cnt == '0);
   // Byte is accepted only when the stop bit samples high
   assign w_rx_push = (r_rx_state == S_STOP) & w_rx_tick & r_rx_s2;

   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_s1   <= uart_rxd;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         if (r_rx_state == S_IDLE) begin
            if (r_en && r_rx_prev && !r_rx_s2) begin
               r_rx_state <= S_START;
               r_rx_cnt   <= w_div_half_m1;   // first sample mid start bit
            end
         end else if (!w_rx_tick) begin
            r_rx_cnt <= r_rx_cnt - DIV_WIDTH'(1);
         end else begin
            r_rx_cnt <= w_div_m1;
            case (r_rx_state)
               S_START: begin
                  r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                  r_rx_bit   <= '0;
               end
               S_DATA: begin
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                  else                  r_rx_bit   <= r_rx_bit + 3'd1;
               end
               default: r_rx_state <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- Registers and IRQ ----------------
   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         r_en     <= 1'b0;
         r_rx_ie  <= 1'b0;
         r_tx_ie  <= 1'b0;
         r_div    <= DIV_WIDTH'(DIV_RESET);
         r_rx_ovf <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_en    <= bus.din[C_CTRL_EN];
            r_rx_ie <= bus.din[C_CTRL_RX_IE];
            r_tx_ie <= bus.din[C_CTRL_TX_IE];
         end
         if (w_wr_div)
            r_div <= (w_div_wr < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : w_div_wr;
         // A push into a full RX FIFO is lost unless the CPU pops that cycle
         if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
         else if (w_wr_stat)                      r_rx_ovf <= 1'b0;
         r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty & ~w_tx_busy) | r_rx_ovf;
      end
   end

   assign bus.irq = r_irq;

   always_comb begin
      bus.dout = '0;
      case (bus.addr)
         UART_DATA: bus.dout = {24'b0, w_rx_rdata};
         UART_STAT: bus.dout = {26'b0, r_rx_ovf, w_rx_full, ~w_rx_empty,
                                w_tx_full, w_tx_empty, w_tx_busy};
         UART_CTRL: bus.dout = {29'b0, r_tx_ie, r_rx_ie, r_en};
         default:   bus.dout = 32'(r_div);
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_periph.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_fifo_periph                                     |
// | Purpose  : Directed self-checking bench for uart_fifo_periph.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_uart_fifo_periph;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic sys_rstn = 1'b0;
   logic rxd_drv = 1'b1;
   logic loop = 1'b0;
   logic txd;
   logic rxd;
   int   tests = 0;
   int   fails = 0;

   uart_fifo_periph_if bus ();

   assign rxd = loop ? txd : rxd_drv;

   uart_fifo_periph #(.FIFO_DEPTH(DEPTH), .DIV_RESET(217), .DIV_WIDTH(16)) dut (
      .clk(clk), .sys_rstn(sys_rstn), .bus(bus), .uart_rxd(rxd), .uart_txd(txd));

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr = a; bus.din = d; bus.we = 1'b1;
      tick(1);
      bus.we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a; bus.re = 1'b1;
      #1 d = bus.dout;
      tick(1);
      bus.re = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb);
      rxd_drv = 1'b0; tick(8);
      for (int k = 0; k < 8; k++) begin rxd_drv = b[k]; tick(8); end
      rxd_drv = stopb; tick(8);
      rxd_drv = 1'b1; tick(16);
   endtask

   // tx_empty is STATUS bit 1, so an idle empty UART reads 0x02
   task automatic test_reset;
      logic [31:0] d;
      sys_rstn = 1'b0; tick(3); sys_rstn = 1'b1; tick(1);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL reset_stat got=%h exp=%h", d, 32'h02); end
      rd(UART_CTRL, d); tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got=%h exp=0", d); end
      rd(UART_DIV, d); tests++;
      if (d !== 32'd217) begin fails++; $display("FAIL reset_div got=%0d exp=217", d); end
      tests++;
      if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd got=%b exp=1", txd); end
      tests++;
      if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
   endtask

   task automatic test_irq_lag;
      wr(UART_CTRL, 32'h4);
      tests++;
      if (bus.irq !== 1'b0) begin fails++; $display("FAIL irq_lag_early got=%b exp=0", bus.irq); end
      tick(1); tests++;
      if (bus.irq !== 1'b1) begin fails++; $display("FAIL irq_tx_ie got=%b exp=1", bus.irq); end
      wr(UART_CTRL, 32'h0);
      tests++;
      if (bus.irq !== 1'b1) begin fails++; $display("FAIL irq_hold got=%b exp=1", bus.irq); end
      tick(1); tests++;
      if (bus.irq !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
   endtask

   task automatic test_tx_frame;
      logic [7:0] b;
      logic       e;
      b = 8'hA5;
      wr(UART_DIV, 32'd4);
      wr(UART_CTRL, 32'h1);
      wr(UART_DATA, 32'hA5);
      bus.addr = UART_STAT;
      tick(1);
      for (int i = 0; i < 40; i++) begin
         e = (i < 4) ? 1'b0 : (i < 36) ? b[(i-4)/4] : 1'b1;
         tests++;
         if (txd !== e || bus.dout[C_ST_TX_BUSY] !== 1'b1) begin
            fails++;
            $display("FAIL tx_frame cyc=%0d txd=%b busy=%b exp txd=%b busy=1", i, txd, bus.dout[0], e);
         end
         tick(1);
      end
      tests++;
      if (txd !== 1'b1 || bus.dout[C_ST_TX_BUSY] !== 1'b0) begin
         fails++; $display("FAIL tx_end txd=%b busy=%b exp txd=1 busy=0", txd, bus.dout[0]);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      logic [7:0]  exp_b [3];
      int          n;
      exp_b[0] = 8'h3C; exp_b[1] = 8'hFF; exp_b[2] = 8'h00;
      loop = 1'b1;
      wr(UART_CTRL, 32'h0);
      wr(UART_DIV, 32'd8);
      for (int i = 0; i < 3; i++) wr(UART_DATA, {24'b0, exp_b[i]});
      wr(UART_CTRL, 32'h1);
      bus.addr = UART_STAT;
      n = 0;
      for (int k = 0; k < 1000; k++) begin
         tick(1);
         if (bus.dout[C_ST_TX_BUSY]) n++;
         else break;
      end
      tests++;
      if (n != 240) begin fails++; $display("FAIL b2b_busy_cycles got=%0d exp=240", n); end
      tick(30);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h0A) begin fails++; $display("FAIL loop_stat got=%h exp=%h", d, 32'h0A); end
      for (int i = 0; i < 3; i++) begin
         rd(UART_DATA, d); tests++;
         if (d !== {24'b0, exp_b[i]}) begin fails++; $display("FAIL loop_data%0d got=%h exp=%h", i, d, exp_b[i]); end
      end
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL loop_drained got=%h exp=%h", d, 32'h02); end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      logic        done;
      for (int i = 0; i <= DEPTH; i++) wr(UART_DATA, 32'h40 + i);
      bus.addr = UART_STAT;
      done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         tick(1);
         if (bus.dout[1:0] == 2'b10) done = 1'b1;
      end
      tests++;
      if (!done) begin fails++; $display("FAIL ovf_tx_timeout got=busy exp=idle"); end
      tick(30);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h3A) begin fails++; $display("FAIL ovf_stat got=%h exp=%h", d, 32'h3A); end
      tests++;
      if (bus.irq !== 1'b1) begin fails++; $display("FAIL ovf_irq got=%b exp=1", bus.irq); end
      for (int i = 0; i < DEPTH; i++) begin
         rd(UART_DATA, d); tests++;
         if (d !== 32'h40 + i) begin fails++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, 32'h40 + i); end
      end
      rd(UART_STAT, d); tests++;
      if (d !== 32'h22) begin fails++; $display("FAIL ovf_sticky got=%h exp=%h", d, 32'h22); end
      wr(UART_STAT, 32'h0);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h02); end
      tests++;
      if (bus.irq !== 1'b0) begin fails++; $display("FAIL ovf_irq_clear got=%b exp=0", bus.irq); end
   endtask

   task automatic test_rx_glitch_framing;
      logic [31:0] d;
      loop = 1'b0; rxd_drv = 1'b1;
      tick(5);
      rxd_drv = 1'b0; tick(2); rxd_drv = 1'b1; tick(40);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL rx_glitch got=%h exp=%h", d, 32'h02); end
      send_rx(8'h55, 1'b0);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL rx_framing got=%h exp=%h", d, 32'h02); end
      send_rx(8'h96, 1'b1);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h0A) begin fails++; $display("FAIL rx_good_stat got=%h exp=%h", d, 32'h0A); end
      rd(UART_DATA, d); tests++;
      if (d !== 32'h96) begin fails++; $display("FAIL rx_good_data got=%h exp=%h", d, 32'h96); end
      rd(UART_DATA, d); tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL rx_empty_read got=%h exp=0", d); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] d;
      wr(UART_CTRL, 32'h0);
      wr(UART_DIV, 32'd4);
      wr(UART_DATA, 32'hA5); wr(UART_DATA, 32'h11); wr(UART_DATA, 32'h22);
      wr(UART_CTRL, 32'h1);
      tick(18);
      tests++;
      if (txd !== 1'b0) begin fails++; $display("FAIL mid_bit3 got=%b exp=0", txd); end
      sys_rstn = 1'b0; tick(1); tests++;
      if (txd !== 1'b1) begin fails++; $display("FAIL mid_rst_txd got=%b exp=1", txd); end
      sys_rstn = 1'b1; tick(1);
      rd(UART_STAT, d); tests++;
      if (d !== 32'h02) begin fails++; $display("FAIL mid_rst_stat got=%h exp=%h", d, 32'h02); end
      rd(UART_CTRL, d); tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL mid_rst_ctrl got=%h exp=0", d); end
      rd(UART_DIV, d); tests++;
      if (d !== 32'd217) begin fails++; $display("FAIL mid_rst_div got=%0d exp=217", d); end
      wr(UART_DIV, 32'd2);
      rd(UART_DIV, d); tests++;
      if (d !== 32'd4) begin fails++; $display("FAIL div_clamp got=%0d exp=4", d); end
      wr(UART_DIV, 32'd5);
      rd(UART_DIV, d); tests++;
      if (d !== 32'd5) begin fails++; $display("FAIL div_noclamp got=%0d exp=5", d); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.addr = UART_DATA; bus.we = 1'b0; bus.re = 1'b0; bus.din = '0;
      test_reset;
      test_irq_lag;
      test_tx_frame;
      test_back_to_back;
      test_overflow;
      test_rx_glitch_framing;
      test_reset_midframe;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
